ccff_chain_loader: RTL and testbench

//  Programs one configuration-chain segment (e.g. a frac_logic ccff chain: frac_lut6 + output mux mem).

---
 rtl/ccff_loader_pkg.sv | 19 +
 rtl/ccff_crc16.sv | 34 +++
 rtl/ccff_chain_loader.sv | 162 ++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-16-CCITT helper for the ccff chain loader.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      VERIFY,
      FIN
   } state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // One serial MSB-first step, no reflection, no final xor.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      return {crc[14:0], 1'b0} ^ (((crc[15] ^ b) == 1'b1) ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/ccff_crc16.sv
// Serial CRC-16 engine: synchronous clear to CRC16_INIT, one bit per enabled cycle.
module ccff_crc16
   import ccff_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        bit_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = CRC16_INIT;
      end else if (en_i) begin
         crc_d = crc16_step(crc_q, bit_i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises a word stream onto a ccff chain with per-bit shift enable and an
// optional recirculating CRC-16 verify pass.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 67,
   parameter int unsigned WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              verify_en,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              chain_shift_en,
   output logic              busy,
   output logic              done,
   output logic              crc_err
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int unsigned WB_W  = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
   localparam logic [WB_W-1:0]  WORD_C = WB_W'(WORD_W);
   localparam logic [WB_W-1:0]  WONE_C = WB_W'(1);

   state_e            state_q, state_d;
   logic              verify_q, verify_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] wreg_q, wreg_d;
   logic [WB_W-1:0]   wbits_q, wbits_d;
   logic              head_q, head_d;
   logic              shift_q, shift_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              issue, crc_clr, rx_en;
   logic [15:0]       tx_crc, rx_crc;

   assign issue     = (state_q == LOAD) && (wbits_q != '0) && (bit_cnt_q != LEN_C);
   assign cfg_ready = (state_q == LOAD) && (wbits_q == '0) && (bit_cnt_q != LEN_C);
   assign crc_clr   = (state_q == IDLE) && start;
   assign rx_en     = (state_q == VERIFY) && shift_q;

   always_comb begin
      state_d   = state_q;
      verify_d  = verify_q;
      bit_cnt_d = bit_cnt_q;
      wreg_d    = wreg_q;
      wbits_d   = wbits_q;
      head_d    = head_q;
      shift_d   = 1'b0;
      done_d    = 1'b0;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD;
               verify_d  = verify_en;
               bit_cnt_d = '0;
               wbits_d   = '0;
               err_d     = 1'b0;
            end
         end
         LOAD: begin
            if (bit_cnt_q == LEN_C) begin
               // Last load shift happens this cycle; verify shifts follow back-to-back.
               wbits_d   = '0;
               bit_cnt_d = '0;
               if (verify_q) begin
                  state_d = VERIFY;
                  shift_d = 1'b1;
               end else begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end
            end else if (issue) begin
               head_d    = wreg_q[WORD_W-1];
               shift_d   = 1'b1;
               wreg_d    = wreg_q << 1;
               wbits_d   = wbits_q - WONE_C;
               bit_cnt_d = bit_cnt_q + ONE_C;
            end else if (cfg_valid) begin
               wreg_d  = cfg_data;
               wbits_d = WORD_C;
            end
         end
         VERIFY: begin
            if (bit_cnt_q == LEN_C) begin
               err_d   = (rx_crc != tx_crc);
               state_d = FIN;
               done_d  = 1'b1;
            end else if (shift_q) begin
               bit_cnt_d = bit_cnt_q + ONE_C;
               shift_d   = (bit_cnt_q != LAST_C);
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_q   <= IDLE;
         verify_q  <= 1'b0;
         bit_cnt_q <= '0;
         wreg_q    <= '0;
         wbits_q   <= '0;
         head_q    <= 1'b0;
         shift_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         verify_q  <= verify_d;
         bit_cnt_q <= bit_cnt_d;
         wreg_q    <= wreg_d;
         wbits_q   <= wbits_d;
         head_q    <= head_d;
         shift_q   <= shift_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   ccff_crc16 u_tx_crc (
      .clk_i (prog_clk),
      .rst_i (pReset),
      .clr_i (crc_clr),
      .en_i  (issue),
      .bit_i (wreg_q[WORD_W-1]),
      .crc_o (tx_crc)
   );

   ccff_crc16 u_rx_crc (
      .clk_i (prog_clk),
      .rst_i (pReset),
      .clr_i (crc_clr),
      .en_i  (rx_en),
      .bit_i (ccff_tail),
      .crc_o (rx_crc)
   );

   // Recirculation needs the tail bit on the same edge it leaves the chain, so
   // VERIFY bypasses head_q; the tail itself only moves on prog_clk edges.
   assign ccff_head      = (state_q == VERIFY) ? ccff_tail : head_q;
   assign chain_shift_en = shift_q;
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign crc_err        = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a behavioural chain and bit scoreboard.
module tb_ccff_chain_loader;

   localparam int L = 67;
   localparam int W = 8;

   logic prog_clk = 1'b0;
   logic pReset = 1'b1;
   logic start_main = 1'b0;
   logic verify_en = 1'b0;
   logic cfg_valid = 1'b0;
   logic flip_en = 1'b0;
   logic [W-1:0] cfg_data = '0;
   logic cfg_ready, ccff_head, ccff_tail, chain_shift_en, busy, done, crc_err;

   logic [L-1:0] chain = '0;
   logic [L-1:0] exp_chain = '0;
   int sh_total = 0;
   int sh_base = 0;
   int done_cnt = 0;
   int errors = 0;
   int checks = 0;
   int pushed = 0;
   bit exp_q[$];
   logic [W-1:0] words [9] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h96, 8'h69, 8'hC3, 8'h5A, 8'hE7};

   always #5 prog_clk = ~prog_clk;

   assign ccff_tail = chain[L-1] ^ (flip_en && ((sh_total - sh_base) == L + 30));

   ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
      .prog_clk       (prog_clk),
      .pReset         (pReset),
      .start          (start_main),
      .verify_en      (verify_en),
      .cfg_data       (cfg_data),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .ccff_head      (ccff_head),
      .ccff_tail      (ccff_tail),
      .chain_shift_en (chain_shift_en),
      .busy           (busy),
      .done           (done),
      .crc_err        (crc_err)
   );

   always @(posedge prog_clk) begin
      if (chain_shift_en === 1'b1) begin
         chain    <= {chain[L-2:0], ccff_head};
         sh_total <= sh_total + 1;
      end
   end

   task automatic check_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_v(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge prog_clk) begin
      bit e;
      if (done === 1'b1) done_cnt++;
      if (!pReset && busy === 1'b1 && chain_shift_en === 1'b1 && (sh_total - sh_base) < L) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=empty expected=pending_bit");
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_b("head_bit", ccff_head, e);
         end
      end
   end

   task automatic start_op(input logic v);
      sh_base = sh_total;
      pushed = 0;
      exp_q.delete();
      verify_en = v;
      start_main = 1'b1;
      @(negedge prog_clk);
      start_main = 1'b0;
      verify_en = 1'b0;
      check_b("start_busy", busy, 1'b1);
      check_b("start_crc_err_clr", crc_err, 1'b0);
      check_b("start_no_shift", chain_shift_en, 1'b0);
   endtask

   task automatic send_words(input int gap_after, input int gap_len, input int inj_bit);
      for (int w = 0; w < 9; w++) begin
         int n;
         if (w == gap_after) begin
            cfg_valid = 1'b0;
            repeat (gap_len) @(negedge prog_clk);
            check_b("gap_no_shift", chain_shift_en, 1'b0);
            check_v("gap_bits", L'(sh_total - sh_base), L'(w * W));
         end
         cfg_data = words[w];
         cfg_valid = 1'b1;
         n = 0;
         while (cfg_ready !== 1'b1 && n < 100) begin
            @(negedge prog_clk);
            n++;
            start_main = (inj_bit >= 0) && ((sh_total - sh_base) == inj_bit);
         end
         start_main = 1'b0;
         check_b("accept_wait", cfg_ready, 1'b1);
         for (int b = W - 1; b >= 0; b--) begin
            if (pushed < L) begin
               exp_q.push_back(words[w][b]);
               exp_chain = {exp_chain[L-2:0], words[w][b]};
               pushed++;
            end
         end
         @(negedge prog_clk);
      end
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 500) begin
         @(negedge prog_clk);
         n++;
      end
      check_b({tag, "_done"}, done, 1'b1);
      check_b({tag, "_fin_busy"}, busy, 1'b1);
      @(negedge prog_clk);
      check_b({tag, "_done_pulse"}, done, 1'b0);
      check_b({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      int d0;
      int n;
      repeat (3) @(negedge prog_clk);
      check_b("rst_ready", cfg_ready, 1'b0);
      check_b("rst_head", ccff_head, 1'b0);
      check_b("rst_shift", chain_shift_en, 1'b0);
      check_b("rst_busy", busy, 1'b0);
      check_b("rst_done", done, 1'b0);
      check_b("rst_crc_err", crc_err, 1'b0);
      pReset = 1'b0;
      @(negedge prog_clk);

      cfg_valid = 1'b1;
      cfg_data = 8'hFF;
      @(negedge prog_clk);
      check_b("idle_ready", cfg_ready, 1'b0);
      check_b("idle_busy", busy, 1'b0);
      check_v("idle_no_shift", L'(sh_total), '0);
      cfg_valid = 1'b0;

      // 1: plain load, valid held high afterwards must not be consumed
      d0 = done_cnt;
      start_op(1'b0);
      send_words(-1, 0, -1);
      cfg_valid = 1'b1;
      cfg_data = 8'hFF;
      wait_done("t1");
      cfg_valid = 1'b0;
      repeat (4) @(negedge prog_clk);
      check_v("t1_shifts", L'(sh_total - sh_base), L'(L));
      check_v("t1_chain", chain, exp_chain);
      check_v("t1_sb_empty", L'(exp_q.size()), '0);
      check_v("t1_done_cnt", L'(done_cnt - d0), L'(1));
      check_b("t1_crc_err", crc_err, 1'b0);

      // 2: load + verify on an ideal chain
      d0 = done_cnt;
      start_op(1'b1);
      send_words(-1, 0, -1);
      wait_done("t2");
      check_v("t2_shifts", L'(sh_total - sh_base), L'(2 * L));
      check_v("t2_chain", chain, exp_chain);
      check_v("t2_done_cnt", L'(done_cnt - d0), L'(1));
      check_b("t2_crc_err", crc_err, 1'b0);

      // 3: tail bit 30 corrupted during verify
      flip_en = 1'b1;
      start_op(1'b1);
      send_words(-1, 0, -1);
      wait_done("t3");
      check_b("t3_crc_err", crc_err, 1'b1);
      check_v("t3_shifts", L'(sh_total - sh_base), L'(2 * L));
      repeat (3) @(negedge prog_clk);
      check_b("t3_crc_err_sticky", crc_err, 1'b1);
      flip_en = 1'b0;

      // 4: 10-cycle gap between words 3 and 4 (start_op checks crc_err cleared)
      d0 = done_cnt;
      start_op(1'b0);
      send_words(3, 10, -1);
      wait_done("t4");
      check_v("t4_shifts", L'(sh_total - sh_base), L'(L));
      check_v("t4_chain", chain, exp_chain);
      check_v("t4_done_cnt", L'(done_cnt - d0), L'(1));

      // 5: start pulsed at bit 20 is ignored
      d0 = done_cnt;
      start_op(1'b0);
      send_words(-1, 0, 20);
      wait_done("t5");
      check_v("t5_shifts", L'(sh_total - sh_base), L'(L));
      check_v("t5_chain", chain, exp_chain);
      check_v("t5_done_cnt", L'(done_cnt - d0), L'(1));

      // 6: async reset at verify shift 40, then a fresh verified load
      d0 = done_cnt;
      start_op(1'b1);
      send_words(-1, 0, -1);
      n = 0;
      while ((sh_total - sh_base) != L + 40 && n < 300) begin
         @(negedge prog_clk);
         n++;
      end
      check_v("t6_reach_shift40", L'(sh_total - sh_base), L'(L + 40));
      pReset = 1'b1;
      #1;
      check_b("t6_rst_ready", cfg_ready, 1'b0);
      check_b("t6_rst_head", ccff_head, 1'b0);
      check_b("t6_rst_shift", chain_shift_en, 1'b0);
      check_b("t6_rst_busy", busy, 1'b0);
      check_b("t6_rst_done", done, 1'b0);
      check_b("t6_rst_crc_err", crc_err, 1'b0);
      @(negedge prog_clk);
      pReset = 1'b0;
      repeat (5) @(negedge prog_clk);
      check_v("t6_no_done", L'(done_cnt - d0), '0);
      check_b("t6_idle_shift", chain_shift_en, 1'b0);
      check_b("t6_idle_busy", busy, 1'b0);
      d0 = done_cnt;
      start_op(1'b1);
      send_words(-1, 0, -1);
      wait_done("t6r");
      check_v("t6r_shifts", L'(sh_total - sh_base), L'(2 * L));
      check_v("t6r_chain", chain, exp_chain);
      check_v("t6r_done_cnt", L'(done_cnt - d0), L'(1));
      check_b("t6r_crc_err", crc_err, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
